// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: shared types, widths and the rotate-priority pick used by
// the delay timer arbiter. Optional feature macro: DELAY_TIMER_PRESCALE_EN
// (handled in the top module).
package delay_timer_pkg;

  localparam int DT_WIDTH   = 7;
  localparam int DT_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dt_state_t;

  // Rotate-priority select over up to 8 requesters: scans ptr, ptr+1, ...
  // (mod nreq) and returns {found, index} of the first set request bit.
  function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input logic [3:0] nreq);
    logic [3:0] pos;
    logic [3:0] res;
    res = 4'd0;
    for (int k = 0; k < DT_MAX_REQ; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= nreq) begin
        pos = pos - nreq;
      end else begin
        pos = pos;
      end
      if ((4'(k) < nreq) && !res[3] && req[pos[2:0]]) begin
        res = {1'b1, pos[2:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Given the request vector and
// the rotating priority pointer, produces the one-hot grant candidate, its
// index and a valid flag. Holds no state.
module rr_arbiter
  import delay_timer_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [NREQ-1:0] gnt_next,
  output logic [PW-1:0]   index,
  output logic            valid
);

  logic [7:0] req_w;
  logic [2:0] ptr_w;
  logic [3:0] pick_unused_s;

  // Widen to the package function's fixed width, pick and decode to one-hot.
  always_comb begin
    req_w             = 8'd0;
    req_w[NREQ-1:0]   = req;
    ptr_w             = 3'd0;
    ptr_w[PW-1:0]     = pointer;
    pick_unused_s     = rr_pick(req_w, ptr_w, 4'(NREQ));
    valid             = pick_unused_s[3];
    index             = pick_unused_s[PW-1:0];
    gnt_next          = '0;
    if (pick_unused_s[3]) begin
      gnt_next[index] = 1'b1;
    end else begin
      gnt_next        = '0;
    end
  end

endmodule

// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter: one shared up-counter time-multiplexed between NREQ
// requesters. The round-robin winner gets its tick count latched, the counter
// runs 0..target while its grant is held, then a one-cycle done pulse follows.
// Optional macro DELAY_TIMER_PRESCALE_EN adds a tick_en input that gates
// counter increments (the completion compare still runs every cycle).
module delay_timer_arbiter
  import delay_timer_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  Reset,
`ifdef DELAY_TIMER_PRESCALE_EN
  input  logic                  tick_en,
`endif
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_ticks,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  dt_state_t        state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  arb_gnt_s;
  logic [PW-1:0]    arb_idx_s;
  logic             arb_valid_s;
  logic             step_s;
  logic [PW-1:0]    ptr_next_s;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req      (req),
    .pointer  (ptr_q),
    .gnt_next (arb_gnt_s),
    .index    (arb_idx_s),
    .valid    (arb_valid_s)
  );

`ifdef DELAY_TIMER_PRESCALE_EN
  assign step_s = tick_en;
`else
  assign step_s = 1'b1;
`endif

  // Priority moves to the requester just after the one that held the counter.
  assign ptr_next_s = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);

  // Next-state logic for the arbitration / run / done sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          state_d  = RUN;
          idx_d    = arb_idx_s;
          target_d = req_ticks[int'(arb_idx_s) * WIDTH +: WIDTH];
          cnt_d    = '0;
          gnt_d    = arb_gnt_s;
          busy_d   = 1'b1;
        end else begin
          gnt_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b0;
        end
      end
      RUN: begin
        if (!req[idx_q]) begin
          // Winner withdrew: release the counter without a done pulse.
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_next_s;
        end else if (cnt_q == target_q) begin
          state_d = DONE;
          gnt_d   = '0;
          done_d  = gnt_q;
          cnt_d   = '0;
          ptr_d   = ptr_next_s;
        end else if (step_s) begin
          cnt_d   = cnt_q + WIDTH'(1);
        end else begin
          cnt_d   = cnt_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by Reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// tb_delay_timer_arbiter: scoreboard bench. Each stimulus step pushes the
// outputs expected for that cycle; a negedge monitor pops and compares.
module tb_delay_timer_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 7;

  logic                  CLK = 1'b0;
  logic                  Reset = 1'b1;
  logic                  tick_en = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_ticks = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      cnt;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic [6:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  delay_timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
`ifdef DELAY_TIMER_PRESCALE_EN
    .tick_en   (tick_en),
`endif
    .req       (req),
    .req_ticks (req_ticks),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .cnt       (cnt)
  );

  always #5 CLK = ~CLK;

  // Cycle index used in comparison tags.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the expectation for this cycle and compare every output.
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check($sformatf("gnt@%0d", cyc),  32'(gnt),  32'(mon_e.gnt));
      check($sformatf("done@%0d", cyc), 32'(done), 32'(mon_e.done));
      check($sformatf("busy@%0d", cyc), 32'(busy), 32'(mon_e.busy));
      check($sformatf("cnt@%0d", cyc),  32'(cnt),  32'(mon_e.cnt));
    end
  end

  // Drive one cycle of inputs and record the outputs expected in that cycle.
  task automatic step(input logic [3:0] r, input logic rst, input logic te,
                      input logic [3:0] eg, input logic [3:0] ed,
                      input logic eb, input logic [6:0] ec);
    @(posedge CLK);
    #1;
    req     = r;
    Reset   = rst;
    tick_en = te;
    sb.push_back(exp_t'{gnt: eg, done: ed, busy: eb, cnt: ec});
  endtask

  task automatic set_ticks(input int i, input logic [6:0] v);
    req_ticks[i*WIDTH +: WIDTH] = v;
  endtask

  // One uncontested request of T ticks starting from IDLE; another requester
  // toggles and scrambles its ticks mid-run to show it is ignored.
  task automatic run_one(input int i, input int t);
    logic [3:0] oh;
    logic [3:0] noise;
    int         nb;
    oh = 4'b0001 << i;
    nb = (i + 1) % NREQ;
    noise = 4'b0001 << nb;
    set_ticks(i, 7'(t));
    step(oh, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    for (int k = 0; k <= t; k++) begin
      if (t >= 4 && k >= 2 && k < t - 1) begin
        set_ticks(nb, 7'($urandom_range(0, 127)));
        step(oh | noise, 1'b0, 1'b1, oh, 4'h0, 1'b1, 7'(k));
      end else begin
        step(oh, 1'b0, 1'b1, oh, 4'h0, 1'b1, 7'(k));
      end
    end
    step(4'h0, 1'b0, 1'b1, 4'h0, oh, 1'b1, 7'd0);
    step(4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] oh;
    logic [3:0] r_next;

    // Reset state
    step(4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    step(4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    step(4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);

    // All four requesting with zero ticks: grants rotate 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_ticks(i, 7'd0);
    step(4'hF, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << order[g];
      r_next = (g == 4) ? 4'h0 : 4'hF;
      step(4'hF,   1'b0, 1'b1, oh,   4'h0, 1'b1, 7'd0);
      step(r_next, 1'b0, 1'b1, 4'h0, oh,   1'b1, 7'd0);
      step(r_next, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    end

    // req[2] alone, T=3
    run_one(2, 3);

    // req[1], T=127: full range, no wrap
    run_one(1, 127);

    // req[3] T=20 aborted at cnt=5 with req[0] pending (pointer now 2)
    set_ticks(3, 7'd20);
    set_ticks(0, 7'd1);
    step(4'b1001, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    for (int k = 0; k <= 5; k++) begin
      step((k == 5) ? 4'b0001 : 4'b1001, 1'b0, 1'b1, 4'b1000, 4'h0, 1'b1, 7'(k));
    end
    step(4'b0001, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    step(4'b0001, 1'b0, 1'b1, 4'b0001, 4'h0, 1'b1, 7'd0);
    step(4'b0001, 1'b0, 1'b1, 4'b0001, 4'h0, 1'b1, 7'd1);
    step(4'b0000, 1'b0, 1'b1, 4'h0, 4'b0001, 1'b1, 7'd0);
    step(4'b0000, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);

`ifdef DELAY_TIMER_PRESCALE_EN
    // Prescaled run: T=2, tick_en every third cycle
    set_ticks(0, 7'd2);
    step(4'b0001, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 7'd0);
    step(4'b0001, 1'b0, 1'b0, 4'b0001, 4'h0, 1'b1, 7'd0);
    step(4'b0001, 1'b0, 1'b0, 4'b0001, 4'h0, 1'b1, 7'd0);
    step(4'b0001, 1'b0, 1'b1, 4'b0001, 4'h0, 1'b1, 7'd0);
    step(4'b0001, 1'b0, 1'b0, 4'b0001, 4'h0, 1'b1, 7'd1);
    step(4'b0001, 1'b0, 1'b0, 4'b0001, 4'h0, 1'b1, 7'd1);
    step(4'b0001, 1'b0, 1'b1, 4'b0001, 4'h0, 1'b1, 7'd1);
    step(4'b0001, 1'b0, 1'b0, 4'b0001, 4'h0, 1'b1, 7'd2);
    step(4'b0000, 1'b0, 1'b1, 4'h0, 4'b0001, 1'b1, 7'd0);
    step(4'b0000, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
`endif

    // Reset mid-run: req[0] T=10, Reset asserted while cnt=4
    set_ticks(0, 7'd10);
    step(4'b0001, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    for (int k = 0; k < 4; k++) begin
      step(4'b0001, 1'b0, 1'b1, 4'b0001, 4'h0, 1'b1, 7'(k));
    end
    step(4'b0001, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    step(4'b0000, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    step(4'b0000, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    step(4'b0000, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);

    // Pointer back at 0 after reset: req 1001 must pick requester 0
    set_ticks(0, 7'd0);
    step(4'b1001, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);
    step(4'b1001, 1'b0, 1'b1, 4'b0001, 4'h0, 1'b1, 7'd0);
    step(4'b0000, 1'b0, 1'b1, 4'h0, 4'b0001, 1'b1, 7'd0);
    step(4'b0000, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 7'd0);

    @(negedge CLK);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Run-time bound in case the stimulus thread stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
